// File: rtl/cx_types_pkg.sv
// ---------------------------------------------------------------------------
// cx_types_pkg
// Shared constants and helpers for the fixed-point datapath blocks.
//   ROUND_TRUNC / ROUND_HALF_UP : selectors for the output rounding mode
//   fp_sum_width()              : width of an aligned product+addend sum
// ---------------------------------------------------------------------------
package cx_types_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;

   // One guard bit on top of the wider of the product and the aligned
   // addend, so that the add or subtract itself can never overflow.
   function automatic int fp_sum_width(input int p, input int cw, input int sh);
      return ((p > (cw + sh)) ? p : (cw + sh)) + 1;
   endfunction

endpackage

// File: rtl/fp_round_sat.sv
// ---------------------------------------------------------------------------
// fp_round_sat
// Combinational precision reduction of a signed sum: drops K fractional
// bits (floor or round-half-up), then saturates or wraps into DW bits.
//   sum        in  IW  signed input value
//   dout_next  out DW  reduced, range-limited result
//   ovf_event  out 1   result did not fit in DW signed bits
// ---------------------------------------------------------------------------
module fp_round_sat
   import cx_types_pkg::*;
#(
   parameter int IW         = 33,
   parameter int K          = 15,
   parameter int DW         = 18,
   parameter int ROUND_MODE = ROUND_TRUNC,
   parameter int SAT        = 1
) (
   input  logic [IW-1:0] sum,
   output logic [DW-1:0] dout_next,
   output logic          ovf_event
);

   // One extra bit so the rounding bias cannot overflow the sum.
   localparam int RW = IW + 1;
   // Range-check width, covering an output that is wider than the sum.
   localparam int XW = (RW > DW) ? RW : DW;

   localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

   logic signed [RW-1:0] sum_ext;
   logic signed [RW-1:0] biased;
   logic signed [RW-1:0] rounded;
   logic signed [XW-1:0] wide;
   logic [XW-DW:0]       upper;
   logic                 out_of_range;

   assign sum_ext = {sum[IW-1], sum};

   // Half-up adds half an output LSB before flooring; with nothing to
   // drop (K = 0) both modes are the identity.
   if ((ROUND_MODE == ROUND_HALF_UP) && (K > 0)) begin : g_half_up
      localparam logic [RW-1:0] HALF = RW'(1) << (K - 1);
      assign biased = sum_ext + $signed(HALF);
   end else begin : g_trunc
      assign biased = sum_ext;
   end

   assign rounded = biased >>> K;
   assign wide    = XW'(rounded);

   // The value fits when every bit from the output sign bit upward is a
   // copy of the same sign.
   assign upper        = wide[XW-1:DW-1];
   assign out_of_range = !((&upper) || (~|upper));

   // Clamp towards the sign of the true result when saturating; otherwise
   // simply keep the low bits (two's complement wrap).
   always_comb begin
      dout_next = wide[DW-1:0];
      ovf_event = out_of_range;
      if ((SAT != 0) && out_of_range) begin
         dout_next = wide[XW-1] ? MIN_VAL : MAX_VAL;
      end
   end

endmodule

// File: rtl/fp_multadd_pipe.sv
// ---------------------------------------------------------------------------
// fp_multadd_pipe
// Pipelined fixed-point dout = a*b + c (or a*b - c) with automatic binary
// point alignment, configurable rounding, saturation or wrap, and a
// valid/ready handshake that stalls the whole pipeline on backpressure.
// Latency from an accepted input to dout_valid is MULT_LAT+2 cycles.
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    in   input sample valid
//   in_ready    out  sample accepted this cycle when in_valid is high
//   a, b, c     in   signed operands (AW/AF, BW/BF, CW/CF)
//   sub         in   1 = a*b - c, 0 = a*b + c
//   dout_valid  out  result valid
//   dout_ready  in   downstream accepts the result
//   dout        out  signed result (DW/DF)
//   ovf         out  sticky flag: some result saturated or wrapped
//   clr_ovf     in   synchronous clear of ovf (a same-cycle set wins)
// ---------------------------------------------------------------------------
module fp_multadd_pipe
   import cx_types_pkg::*;
#(
   parameter int AW         = 16,
   parameter int AF         = 15,
   parameter int BW         = 16,
   parameter int BF         = 15,
   parameter int CW         = 16,
   parameter int CF         = 15,
   parameter int DW         = 18,
   parameter int DF         = 15,
   parameter int MULT_LAT   = 2,
   parameter int ROUND_MODE = ROUND_TRUNC,
   parameter int SAT        = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] a,
   input  logic [BW-1:0] b,
   input  logic [CW-1:0] c,
   input  logic          sub,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [DW-1:0] dout,
   output logic          ovf,
   input  logic          clr_ovf
);

   localparam int P  = AW + BW;
   localparam int PF = AF + BF;
   localparam int SH = PF - CF;
   localparam int SW = fp_sum_width(P, CW, SH);
   localparam int K  = PF - DF;

   if (CF > AF + BF) begin : g_bad_cf
      $fatal(1, "fp_multadd_pipe: CF must not exceed AF+BF");
   end
   if (DF > AF + BF) begin : g_bad_df
      $fatal(1, "fp_multadd_pipe: DF must not exceed AF+BF");
   end
   if (MULT_LAT < 1) begin : g_bad_lat
      $fatal(1, "fp_multadd_pipe: MULT_LAT must be at least 1");
   end

   logic              en;
   logic [P-1:0]      a_ext;
   logic [P-1:0]      b_ext;

   logic [P-1:0]      prod_q  [1:MULT_LAT];
   logic [CW-1:0]     c_q     [1:MULT_LAT];
   logic              sub_q   [1:MULT_LAT];
   logic              valid_q [1:MULT_LAT];

   logic signed [SW-1:0] prod_al;
   logic signed [SW-1:0] c_al;
   logic signed [SW-1:0] sum_d;
   logic signed [SW-1:0] sum_q;
   logic                 sum_valid_q;

   logic [DW-1:0]        dout_next;
   logic                 ovf_event;

   // The whole pipeline moves together: it may advance whenever the output
   // register is empty or is being drained this cycle.
   assign en       = !dout_valid || dout_ready;
   assign in_ready = en;

   // Sign-extend both operands to the full product width so that the low
   // P bits of the multiply are the exact signed product.
   assign a_ext = {{BW{a[AW-1]}}, a};
   assign b_ext = {{AW{b[BW-1]}}, b};

   // Multiplier register chain. The addend and operation select travel
   // alongside the product so they meet it at the adder stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i <= MULT_LAT; i++) begin
            prod_q[i]  <= '0;
            c_q[i]     <= '0;
            sub_q[i]   <= 1'b0;
            valid_q[i] <= 1'b0;
         end
      end else if (en) begin
         prod_q[1]  <= a_ext * b_ext;
         c_q[1]     <= c;
         sub_q[1]   <= sub;
         valid_q[1] <= in_valid;
         for (int i = 2; i <= MULT_LAT; i++) begin
            prod_q[i]  <= prod_q[i-1];
            c_q[i]     <= c_q[i-1];
            sub_q[i]   <= sub_q[i-1];
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   // Bring the addend onto the product's binary point, both sign-extended
   // to the guarded sum width.
   assign prod_al = $signed({{(SW-P){prod_q[MULT_LAT][P-1]}}, prod_q[MULT_LAT]});
   assign c_al    = $signed({{(SW-CW){c_q[MULT_LAT][CW-1]}}, c_q[MULT_LAT]}) <<< SH;
   assign sum_d   = sub_q[MULT_LAT] ? (prod_al - c_al) : (prod_al + c_al);

   // Adder stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
      end else if (en) begin
         sum_q       <= sum_d;
         sum_valid_q <= valid_q[MULT_LAT];
      end
   end

   fp_round_sat #(
      .IW         (SW),
      .K          (K),
      .DW         (DW),
      .ROUND_MODE (ROUND_MODE),
      .SAT        (SAT)
   ) u_round_sat (
      .sum       (sum_q),
      .dout_next (dout_next),
      .ovf_event (ovf_event)
   );

   // Output register. It only loads when the pipeline advances, so a
   // stalled result stays put until downstream takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (en) begin
         dout       <= dout_next;
         dout_valid <= sum_valid_q;
      end
   end

   // Sticky overflow flag. A real sample overflowing in the same cycle as
   // a clear request keeps the flag set so the event is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (en && sum_valid_q && ovf_event) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_multadd_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_multadd_pipe
// Directed bench for fp_multadd_pipe. Four instances share the input
// stimulus: default (18-bit, truncate, saturate), half-up rounding, and
// 16-bit outputs with saturation and with wrap.
// ---------------------------------------------------------------------------
module tb_fp_multadd_pipe;
   import cx_types_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] c;
   logic        sub;
   logic        dout_ready;
   logic        clr_ovf;

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        dv0, dv1, dv2, dv3;
   logic [17:0] d0, d1;
   logic [15:0] d2, d3;
   logic        ovf0, ovf1, ovf2, ovf3;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   fp_multadd_pipe u_trunc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .a(a), .b(b), .c(c), .sub(sub), .dout_valid(dv0),
      .dout_ready(dout_ready), .dout(d0), .ovf(ovf0), .clr_ovf(clr_ovf)
   );

   fp_multadd_pipe #(.ROUND_MODE(ROUND_HALF_UP)) u_half (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .a(a), .b(b), .c(c), .sub(sub), .dout_valid(dv1),
      .dout_ready(dout_ready), .dout(d1), .ovf(ovf1), .clr_ovf(clr_ovf)
   );

   fp_multadd_pipe #(.DW(16), .SAT(1)) u_sat16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .a(a), .b(b), .c(c), .sub(sub), .dout_valid(dv2),
      .dout_ready(dout_ready), .dout(d2), .ovf(ovf2), .clr_ovf(clr_ovf)
   );

   fp_multadd_pipe #(.DW(16), .SAT(0)) u_wrap16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
      .a(a), .b(b), .c(c), .sub(sub), .dout_valid(dv3),
      .dout_ready(dout_ready), .dout(d3), .ovf(ovf3), .clr_ovf(clr_ovf)
   );

   // One immediate assertion per comparison; failures are counted and
   // reported but the run carries on to the summary.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present one sample for exactly one cycle; returns one negedge later.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                input logic [15:0] cv, input logic sv);
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      c        = cv;
      sub      = sv;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Hard stop if something wedges the directed sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          kNext;
      int          expK;
      logic        stalled;
      logic [17:0] heldVal;
      logic [3:0]  readyPat;
      logic [4:0]  bubPat;
      logic        sawValid;

      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      c          = '0;
      sub        = 1'b0;
      dout_ready = 1'b1;
      clr_ovf    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_dout_valid", 64'(dv0), 64'd0);
      checkOutput("reset_dout", 64'(d0), 64'd0);
      checkOutput("reset_ovf", 64'(ovf0), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready", 64'(rdy0), 64'd1);

      // 0.5*0.5 + 0.25 = 0.5 -> 0x04000, valid exactly four cycles later
      applyStimulus(16'h4000, 16'h4000, 16'h2000, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("basic_not_early", 64'(dv0), 64'd0);
      @(negedge clk);
      checkOutput("basic_valid", 64'(dv0), 64'd1);
      checkOutput("basic_dout", 64'(d0), 64'h04000);
      checkOutput("basic_ovf", 64'(ovf0), 64'd0);

      // 0.5*0.5 - 0.25 = 0
      applyStimulus(16'h4000, 16'h4000, 16'h2000, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("sub_valid", 64'(dv0), 64'd1);
      checkOutput("sub_dout", 64'(d0), 64'h00000);

      // Product of 2^-16: floor gives 0, half-up gives one LSB
      applyStimulus(16'h0001, 16'h4000, 16'h0000, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("round_pos_trunc", 64'(d0), 64'h00000);
      checkOutput("round_pos_half", 64'(d1), 64'h00001);

      // Product of -2^-16: floor gives -1 LSB, half-up gives 0
      applyStimulus(16'hFFFF, 16'h4000, 16'h0000, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("round_neg_trunc", 64'(d0), 64'h3FFFF);
      checkOutput("round_neg_half", 64'(d1), 64'h00000);

      // (-1)*(-1) + 0x7FFF LSBs = 0xFFFF LSBs: fits in 18 bits, not in 16
      applyStimulus(16'h8000, 16'h8000, 16'h7FFF, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("sat_ovf_before", 64'(ovf2), 64'd0);
      @(negedge clk);
      checkOutput("sat_dout", 64'(d2), 64'h7FFF);
      checkOutput("sat_ovf", 64'(ovf2), 64'd1);
      checkOutput("wrap_dout", 64'(d3), 64'hFFFF);
      checkOutput("wrap_ovf", 64'(ovf3), 64'd1);
      checkOutput("wide_dout", 64'(d0), 64'h0FFFF);
      checkOutput("wide_ovf", 64'(ovf0), 64'd0);

      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      checkOutput("clr_sat_ovf", 64'(ovf2), 64'd0);
      checkOutput("clr_wrap_ovf", 64'(ovf3), 64'd0);

      // Backpressure: a=k, b~1.0 gives k-1 after truncation
      kNext    = 1;
      expK     = 1;
      stalled  = 1'b0;
      heldVal  = '0;
      readyPat = 4'b1001;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (expK > 8) break;
         @(negedge clk);
         if (stalled) begin
            checkOutput("bp_hold_valid", 64'(dv0), 64'd1);
            checkOutput("bp_hold_dout", 64'(d0), 64'(heldVal));
         end
         dout_ready = readyPat[cyc % 4];
         #1;
         checkOutput("bp_in_ready", 64'(rdy0), 64'(!dv0 || dout_ready));
         if (dv0 && dout_ready) begin
            checkOutput("bp_order", 64'(d0), 64'(expK - 1));
            expK++;
         end
         stalled  = dv0 && !dout_ready;
         heldVal  = d0;
         in_valid = (kNext <= 8);
         a        = 16'(kNext);
         b        = 16'h7FFF;
         c        = 16'h0000;
         sub      = 1'b0;
         if (in_valid && rdy0) kNext++;
      end
      checkOutput("bp_all_delivered", 64'(expK), 64'd9);
      in_valid   = 1'b0;
      dout_ready = 1'b1;
      sawValid   = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (dv0) sawValid = 1'b1;
      end
      checkOutput("bp_no_duplicate", 64'(sawValid), 64'd0);

      // Bubbles: 1,0,1,1,0 must reappear on dout_valid four cycles later
      bubPat = 5'b01101;
      b      = 16'h7FFF;
      c      = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 4) begin
            checkOutput("bubble_valid", 64'(dv0), 64'(bubPat[i-4]));
            if (bubPat[i-4]) checkOutput("bubble_dout", 64'(d0), 64'(i - 4));
         end else begin
            checkOutput("bubble_idle", 64'(dv0), 64'd0);
         end
         if (i < 5) in_valid = bubPat[i];
         else in_valid = 1'b0;
         a = 16'(i + 1);
      end

      // Reset mid-flight with ovf set and a result on the output
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a        = 16'h8000;
         b        = 16'h8000;
         c        = 16'h7FFF;
         sub      = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_pre_valid", 64'(dv0), 64'd1);
      checkOutput("rst_pre_ovf", 64'(ovf2), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_valid", 64'(dv0), 64'd0);
      checkOutput("rst_async_valid16", 64'(dv2), 64'd0);
      checkOutput("rst_async_ovf", 64'(ovf2), 64'd0);
      checkOutput("rst_async_dout", 64'(d0), 64'd0);
      @(negedge clk);
      rst      = 1'b0;
      sawValid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (dv0 || dv2) sawValid = 1'b1;
      end
      checkOutput("rst_no_stale", 64'(sawValid), 64'd0);
      checkOutput("rst_ovf_stays_clear", 64'(ovf2), 64'd0);

      applyStimulus(16'h4000, 16'h4000, 16'h2000, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("rst_after_valid", 64'(dv0), 64'd1);
      checkOutput("rst_after_dout", 64'(d0), 64'h04000);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fp_multadd_pipe.md
Name: fp_multadd_pipe

Overview:
- Parametrised fixed-point multiply-add pipeline: computes dout = a*b + c, or a*b - c per sample.
- Binary points are aligned automatically. Output precision is reduced by a configurable rounding mode, then saturated or wrapped.
- A valid/ready handshake with a full-pipeline stall supports backpressure; a sticky overflow flag records saturation events.
- Generalised successor of the fixed multadd used in PFB FIR tap accumulation.

Parameters:
- AW, 16, a width (signed)
- AF, 15, a fractional bits
- BW, 16, b width (signed)
- BF, 15, b fractional bits
- CW, 16, c width (signed)
- CF, 15, c fractional bits
- DW, 18, dout width (signed)
- DF, 15, dout fractional bits
- MULT_LAT, 2, multiplier register stages (>=1)
- ROUND_MODE, ROUND_TRUNC, ROUND_TRUNC (floor) or ROUND_HALF_UP
- SAT, 1, 1 = saturate on overflow, 0 = wrap

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts the sample this cycle
- a  in  AW  multiplicand
- b  in  BW  multiplier
- c  in  CW  addend
- sub  in  1  1 = a*b - c, 0 = a*b + c
- dout_valid  out  1  output valid
- dout_ready  in  1  downstream accepts the output
- dout  out  DW  result
- ovf  out  1  sticky: set when any output saturated or wrapped
- clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Single clock domain clk. rst is asynchronous, active-high.
- On reset, all pipeline data registers = 0, all stage valids = 0, dout = 0, dout_valid = 0, ovf = 0. in_ready = 1 once rst deasserts.
- Elaboration checks (fatal assertion):
  - CF <= AF+BF
  - DF <= AF+BF
  - MULT_LAT >= 1
- Width rules:
  - P = AW+BW, PF = AF+BF, SH = PF-CF.
  - c_al = sign-extended c <<< SH.
  - Sum width SW = max(P, CW+SH)+1, fraction PF.
  - Reduce by K = PF-DF bits:
    - TRUNC: arithmetic >>> K.
    - HALF_UP: add 2^(K-1) (when K>0), then >>> K, held at SW+1 bits.
  - Range check against DW signed:
    - SAT=1: clamp to [-2^(DW-1), 2^(DW-1)-1].
    - SAT=0: keep low DW bits.
  - Either case on out-of-range: the ovf_event for that sample = 1.
- Pipeline, LAT = MULT_LAT + 2 cycles from accepted input to dout_valid:
  - Stages 1..MULT_LAT: product register chain, with c and sub delayed alongside.
  - Stage MULT_LAT+1: add or subtract.
  - Stage MULT_LAT+2: round/saturate, registered onto dout.
- Handshake:
  - en = !dout_valid || dout_ready; in_ready = en.
  - Accept when in_valid && in_ready.
  - All stages, valid bits included, advance only when en = 1. When en = 0 every register holds.
  - Bubbles (in_valid=0 while en=1) propagate as valid=0 slots.
  - No combinational path from in_valid to dout.
- Throughput: one sample per cycle while dout_ready = 1.
- dout holds its value while dout_valid && !dout_ready.
- ovf:
  - Set in the cycle the stage-(MULT_LAT+2) register loads a valid sample with ovf_event.
  - clr_ovf clears it; if a set and clr_ovf occur in the same cycle, set wins.
- Reset mid-operation: in-flight samples are discarded immediately (dout_valid drops asynchronously). No stale output appears after rst release.

Decomposition:
- cx_types_pkg additions:
  - ROUND_TRUNC = 0, ROUND_HALF_UP = 1 localparams.
  - function fp_sum_width(P, CW, SH) returning SW.
- One sub-module: fp_round_sat, combinational, parameters IW, K, DW, ROUND_MODE, SAT. Takes the sum and produces dout_next and ovf_event.
- The top level owns all registers.

Test Plan:
- Basic: a=0x4000, b=0x4000, c=0x2000, sub=0 (0.5*0.5+0.25) -> dout=0x04000 exactly 4 cycles after acceptance, ovf=0. Same inputs with sub=1 -> dout=0x00000.
- Rounding: a=0x0001, b=0x4000, c=0 (product 2^-16) -> TRUNC dout=0, HALF_UP dout=1. Then a=0xFFFF, b=0x4000 -> TRUNC dout=0x3FFFF (-1 LSB), HALF_UP dout=0.
- Saturation, override DW=16: a=0x8000, b=0x8000, c=0x7FFF -> SAT=1 dout=0x7FFF with ovf rising; SAT=0 dout=wrapped low 16 bits with ovf=1. clr_ovf pulse -> ovf=0.
- Backpressure: stream 8 values 1..8 (a=k, b=0x7FFF, c=0) while dout_ready toggles 1,0,0,1,... -> in_ready tracks en, dout holds while stalled, all 8 results appear in order, none lost or duplicated.
- Bubbles/throughput: in_valid pattern 1,0,1,1,0 with dout_ready=1 -> dout_valid reproduces the same pattern delayed by 4 cycles.
- Reset mid-flight: 3 samples accepted, rst asserted asynchronously mid-cycle -> dout_valid=0 and ovf=0 at once. After release no outputs appear until new inputs are accepted.
